// File: rtl/cfg_mux_pipe.sv
// cfg_mux_pipe: N_INPUTS:1 configurable input mux with a serially loaded selector and
// optional per-level pipeline registers in the binary mux tree.
//
// Optional feature macro: CFG_SHADOW_EN
//   defined   - the config chain is a shadow register; cfg_commit copies it into the
//               active selector, and samples keep flowing while the chain shifts.
//   undefined - the config chain is the active selector; samples offered while the
//               chain shifts are dropped, and cfg_commit is ignored.
//
// Every sample carries its own selector, valid and out-of-range flag down the tree, so
// reconfiguration never disturbs samples already in flight.
module cfg_mux_pipe #(
  parameter int unsigned N_INPUTS  = 44,
  parameter logic [31:0] STAGE_REG = 32'h15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] data_in,
  input  logic                in_valid,
  output logic                data_out,
  output logic                out_valid,
  output logic                sel_oor,
  input  logic                cfg_en,
  input  logic                cfg_in,
  output logic                cfg_out,
  input  logic                cfg_commit
);

  localparam int unsigned SEL_W = $clog2(N_INPUTS);
  // Input vector padded to a full power of two so every level halves cleanly.
  localparam int unsigned NP = 1 << SEL_W;
  localparam logic [SEL_W:0] NIn = (SEL_W + 1)'(N_INPUTS);

  // ---------------------------------------------------------------------------------------
  // Serial configuration chain (MSB shifted in first, MSB leaves on cfg_out)
  // ---------------------------------------------------------------------------------------
  logic [SEL_W-1:0] chain_q, chain_d;
  logic [SEL_W-1:0] sel_act;
  logic             accept;

  // Shift one bit in at the LSB; truncation drops the outgoing MSB.
  always_comb begin
    chain_d = chain_q;
    if (cfg_en) begin
      chain_d = SEL_W'({chain_q, cfg_in});
    end
  end

  // Chain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign cfg_out = chain_q[SEL_W-1];

`ifdef CFG_SHADOW_EN
  logic [SEL_W-1:0] active_q, active_d;

  // Commit takes the pre-shift chain value even when a shift happens on the same edge.
  always_comb begin
    active_d = active_q;
    if (cfg_commit) begin
      active_d = chain_q;
    end
  end

  // Active selector register, isolated from the shifting chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
    end else begin
      active_q <= active_d;
    end
  end

  assign sel_act = active_q;
  assign accept  = in_valid;
`else
  // The chain is the live selector, so it is unstable while shifting: drop samples then.
  assign sel_act = chain_q;
  assign accept  = in_valid & ~cfg_en;

  logic unused_commit;
  assign unused_commit = cfg_commit;
`endif

  // ---------------------------------------------------------------------------------------
  // Mux tree. Index k is the input side of level k; index SEL_W is the tree output.
  // ---------------------------------------------------------------------------------------
  logic [NP-1:0]    lvl_data [SEL_W+1];
  logic [SEL_W-1:0] lvl_sel  [SEL_W+1];
  logic             lvl_vld  [SEL_W+1];
  logic             lvl_oor  [SEL_W+1];

  assign lvl_data[0] = NP'(data_in);
  assign lvl_sel[0]  = sel_act;
  assign lvl_vld[0]  = accept;
  assign lvl_oor[0]  = ({1'b0, sel_act} >= NIn);

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int unsigned Half = NP >> (k + 1);
    localparam logic [NP-1:0] Mask = {NP{1'b1}} >> (NP - Half);

    logic [NP-1:0] mux_data;

    // Selector bit SEL_W-1-k picks the upper or lower half of the live vector.
    always_comb begin
      mux_data = lvl_data[k];
      if (lvl_sel[k][SEL_W-1-k]) begin
        mux_data = lvl_data[k] >> Half;
      end
      mux_data = mux_data & Mask;
    end

    if (STAGE_REG[k]) begin : g_reg
      logic [NP-1:0]    data_q;
      logic [SEL_W-1:0] sel_q;
      logic             vld_q;
      logic             oor_q;

      // Valid advances every cycle; payload loads only with a valid sample and holds
      // otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          sel_q  <= '0;
          vld_q  <= 1'b0;
          oor_q  <= 1'b0;
        end else begin
          vld_q <= lvl_vld[k];
          if (lvl_vld[k]) begin
            data_q <= mux_data;
            sel_q  <= lvl_sel[k];
            oor_q  <= lvl_oor[k];
          end
        end
      end

      assign lvl_data[k+1] = data_q;
      assign lvl_sel[k+1]  = sel_q;
      assign lvl_vld[k+1]  = vld_q;
      assign lvl_oor[k+1]  = oor_q;
    end else begin : g_comb
      assign lvl_data[k+1] = mux_data;
      assign lvl_sel[k+1]  = lvl_sel[k];
      assign lvl_vld[k+1]  = lvl_vld[k];
      assign lvl_oor[k+1]  = lvl_oor[k];
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  // rst_n gating makes out_valid drop at the reset edge even in the zero-latency build.
  assign out_valid = lvl_vld[SEL_W] & rst_n;
  assign sel_oor   = out_valid & lvl_oor[SEL_W];
  assign data_out  = lvl_data[SEL_W][0] & ~lvl_oor[SEL_W];

  // Upper tree-output bits are always zero and the final selector is fully consumed.
  logic unused_tail;
  assign unused_tail = ^{lvl_data[SEL_W][NP-1:1], lvl_sel[SEL_W]};

endmodule

// File: tb/tb_cfg_mux_pipe.sv
// Scoreboard bench for cfg_mux_pipe: stimulus pushes expected samples (with the cycle they
// are due) into per-DUT queues; monitors pop and compare whenever a DUT shows out_valid.
module tb_cfg_mux_pipe;

`ifdef CFG_SHADOW_EN
  localparam bit Shadow = 1'b1;
`else
  localparam bit Shadow = 1'b0;
`endif

  localparam logic [43:0] PatA = 44'h000_0000_0020; // bit 5 set, bit 20 clear
  localparam logic [43:0] Ones = {44{1'b1}};
  localparam logic [7:0]  Pat8 = 8'b1011_0010;

  typedef struct packed {
    int unsigned due;
    logic        d;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Default-parameter DUT (44 inputs, latency 3).
  logic [43:0] data_in = '0;
  logic in_valid = 1'b0, cfg_en = 1'b0, cfg_in = 1'b0, cfg_commit = 1'b0;
  logic do44, ov44, oor44, cfgo44;

  // Two 8-input DUTs sharing stimulus: zero-latency and fully pipelined.
  logic [7:0] d8 = '0;
  logic v8 = 1'b0, e8 = 1'b0, ci8 = 1'b0, com8 = 1'b0;
  logic do8, ov8, oor8, cfgo8;
  logic dof, ovf, oorf, cfgof;

  exp_t q44[$];
  exp_t q8[$];
  exp_t qf[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [5:0] m_chain = '0, m_act = '0;
  logic [2:0] m8_chain = '0, m8_act = '0;

  cfg_mux_pipe dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .data_out(do44), .out_valid(ov44), .sel_oor(oor44),
    .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfgo44), .cfg_commit(cfg_commit)
  );

  cfg_mux_pipe #(.N_INPUTS(8), .STAGE_REG(32'h0)) dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(d8), .in_valid(v8),
    .data_out(do8), .out_valid(ov8), .sel_oor(oor8),
    .cfg_en(e8), .cfg_in(ci8), .cfg_out(cfgo8), .cfg_commit(com8)
  );

  cfg_mux_pipe #(.N_INPUTS(8), .STAGE_REG(32'hFFFF_FFFF)) dutf (
    .clk(clk), .rst_n(rst_n), .data_in(d8), .in_valid(v8),
    .data_out(dof), .out_valid(ovf), .sel_oor(oorf),
    .cfg_en(e8), .cfg_in(ci8), .cfg_out(cfgof), .cfg_commit(com8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitors: pop on out_valid, flag a due-but-absent sample as a missing valid.
  always @(negedge clk) if (rst_n) begin : mon44
    exp_t e;
    if (ov44) begin
      if (q44.size() == 0) cmp("dut44 unexpected out_valid", ov44, 0);
      else begin
        e = q44.pop_front();
        cmp("dut44 latency", cyc, e.due);
        cmp("dut44 data_out", do44, e.d);
        cmp("dut44 sel_oor", oor44, e.o);
      end
    end else if (q44.size() != 0 && q44[0].due <= cyc) begin
      e = q44.pop_front();
      cmp("dut44 missing out_valid", ov44, 1);
    end
  end

  always @(negedge clk) if (rst_n) begin : mon8
    exp_t e;
    if (ov8) begin
      if (q8.size() == 0) cmp("dut8 unexpected out_valid", ov8, 0);
      else begin
        e = q8.pop_front();
        cmp("dut8 latency", cyc, e.due);
        cmp("dut8 data_out", do8, e.d);
        cmp("dut8 sel_oor", oor8, e.o);
      end
    end else if (q8.size() != 0 && q8[0].due <= cyc) begin
      e = q8.pop_front();
      cmp("dut8 missing out_valid", ov8, 1);
    end
  end

  always @(negedge clk) if (rst_n) begin : monf
    exp_t e;
    if (ovf) begin
      if (qf.size() == 0) cmp("dutf unexpected out_valid", ovf, 0);
      else begin
        e = qf.pop_front();
        cmp("dutf latency", cyc, e.due);
        cmp("dutf data_out", dof, e.d);
        cmp("dutf sel_oor", oorf, e.o);
      end
    end else if (qf.size() != 0 && qf[0].due <= cyc) begin
      e = qf.pop_front();
      cmp("dutf missing out_valid", ovf, 1);
    end
  end

  // One cycle of stimulus on the 44-input DUT; expectation uses the pre-edge selector.
  task automatic step(input logic v, input logic [43:0] d, input logic en, input logic ci,
                      input logic com);
    logic [5:0] sel;
    exp_t       e;
    in_valid = v; data_in = d; cfg_en = en; cfg_in = ci; cfg_commit = com;
    sel = Shadow ? m_act : m_chain;
    if (v && (Shadow || !en)) begin
      e.due = cyc + 3;
      e.o   = (sel >= 6'd44);
      e.d   = e.o ? 1'b0 : d[sel];
      q44.push_back(e);
    end
    cmp("dut44 cfg_out", cfgo44, m_chain[5]);
    if (Shadow && com) m_act = m_chain;
    if (en) m_chain = {m_chain[4:0], ci};
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] s);
    for (int i = 5; i >= 0; i--) step(1'b0, '0, 1'b1, s[i], 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic step8(input logic v, input logic [7:0] d, input logic en, input logic ci,
                       input logic com);
    logic [2:0] sel;
    exp_t       e;
    v8 = v; d8 = d; e8 = en; ci8 = ci; com8 = com;
    sel = Shadow ? m8_act : m8_chain;
    if (v && (Shadow || !en)) begin
      e.o   = 1'b0;
      e.d   = d[sel];
      e.due = cyc;
      q8.push_back(e);
      e.due = cyc + 3;
      qf.push_back(e);
    end
    cmp("dut8 cfg_out", cfgo8, m8_chain[2]);
    cmp("dutf cfg_out", cfgof, m8_chain[2]);
    if (Shadow && com) m8_act = m8_chain;
    if (en) m8_chain = {m8_chain[1:0], ci};
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [2:0] s);
    for (int i = 2; i >= 0; i--) step8(1'b0, '0, 1'b1, s[i], 1'b0);
    step8(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2;
    cmp("reset out_valid", ov44, 0);
    cmp("reset data_out", do44, 0);
    cmp("reset sel_oor", oor44, 0);
    cmp("reset cfg_out", cfgo44, 0);
    cmp("reset dutf out_valid", ovf, 0);
    cmp("reset dutf cfg_out", cfgof, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Selector 37, only bit 37 set.
    load(6'd37);
    step(1'b1, 44'h1 << 37, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Selector 50 is out of range: cfg_out replays 37 (1,0,0,1,0,1) while shifting.
    load(6'd50);
    step(1'b1, Ones, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Continuous samples across a shift of 20 and a commit; 5 -> 1, 20 -> 0.
    load(6'd5);
    repeat (3) step(1'b1, PatA, 1'b0, 1'b0, 1'b0);
    for (int i = 5; i >= 0; i--) step(1'b1, PatA, 1'b1, 1'(6'd20 >> i), 1'b0);
    repeat (3) step(1'b1, PatA, 1'b0, 1'b0, 1'b0);
    step(1'b1, PatA, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, PatA, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reset with samples in flight: out_valid must drop at once, nothing stale afterwards.
    repeat (3) step(1'b1, Ones, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 cmp("pre-reset out_valid", ov44, 1);
    rst_n = 1'b0;
    #1;
    cmp("async reset out_valid", ov44, 0);
    cmp("async reset sel_oor", oor44, 0);
    cmp("async reset data_out", do44, 0);
    q44.delete();
    m_chain = '0;
    m_act = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // 8-input DUTs: every index, both data polarities.
    for (int i = 0; i < 8; i++) begin
      load8(3'(i));
      step8(1'b1, Pat8, 1'b0, 1'b0, 1'b0);
      step8(1'b1, ~Pat8, 1'b0, 1'b0, 1'b0);
    end
    repeat (5) step8(1'b0, '0, 1'b0, 1'b0, 1'b0);

    cmp("dut44 queue drained", q44.size(), 0);
    cmp("dut8 queue drained", q8.size(), 0);
    cmp("dutf queue drained", qf.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
